deserializer_fsm: RTL and testbench
===================================

# deserializer_fsm

Serial-to-parallel stage that collects a single-bit stream, LSB first, into LENGTH-bit words and presents each word on a parallel valid/ready interface. It sits directly downstream of the bit-serial output of the systolic matmul datapath and feeds the parallel result consumer. Shift register and output register are separate, so the next word shifts in while the previous one waits for the consumer.

## Interface
- LENGTH, 24: word width in bits; minimum 2.
- TIMEOUT, 32: idle-cycle limit for a partial word; minimum 1; used only with DESERIALIZER_TIMEOUT_EN.

- i_clk  input  1  clock; all registers on rising edge.
- i_rst_n  input  1  one clock; reset is asynchronous and active-low.
- i_en  input  1  clock enable; low freezes all state and forces o_ready low.
- i_din  input  1  serial data bit.
- i_din_valid  input  1  i_din carries a bit this cycle.
- o_ready  output  1  stage accepts a bit this cycle; combinational: i_rst_n & i_en & (state != STALL).
- ov_dout  output  LENGTH  assembled word; bit 0 = first bit received.
- o_dout_valid  output  1  ov_dout holds an unconsumed word.
- i_ready  input  1  consumer takes ov_dout when high with o_dout_valid.
- o_timeout  output  1  one-cycle pulse when a partial word is discarded.

## Operation
- Accept = i_en & i_din_valid & o_ready. Drain = i_en & o_dout_valid & i_ready.
- On accept: shift_reg <= {i_din, shift_reg[LENGTH-1:1]}; count <= count+1. The counter is $clog2(LENGTH+1) bits wide.
- States:
  - IDLE: count = 0. Accept -> SHIFT.
  - SHIFT: partial word. The LENGTH-th accept completes the word.
  - STALL: full word held in shift_reg because the output register is occupied.
- Word completion (accept with count == LENGTH-1):
  - If !o_dout_valid or drain: ov_dout <= {i_din, shift_reg[LENGTH-1:1]}, o_dout_valid <= 1, count <= 0, state -> IDLE.
  - Otherwise: shift_reg completes, state -> STALL, o_ready drops.
- STALL: on drain, ov_dout <= shift_reg, o_dout_valid stays 1, count <= 0, state -> IDLE. No bits are accepted in STALL.
- Drain without a new load clears o_dout_valid. ov_dout keeps its last value.
- While i_en is low, all registers hold, including the timeout counter.
- Any invalid state encoding recovers to IDLE on the next enabled edge.

## Timing
- Reset values (asynchronous, while i_rst_n low):
  - state IDLE; count 0; shift_reg 0.
  - ov_dout 0; o_dout_valid 0; o_timeout 0; o_ready 0.
- Latency: o_dout_valid rises on the clock edge that registers the LENGTH-th accepted bit.
- Throughput: with continuous input and i_ready high, one word every LENGTH accepted cycles, with no bubble on o_ready.
- Simultaneous completion and drain in the same cycle: the new word replaces the old; o_dout_valid stays high; there is no STALL.
- Reset mid-word: the partial word is lost. The first accept after release is bit 0 of a new word.
- i_din_valid high while o_ready is low: the bit is ignored, and the upstream stage must hold it.

## Configuration
- Macro: DESERIALIZER_TIMEOUT_EN.
- Defined:
  - A timer counts enabled cycles in SHIFT with no accept, and clears on each accept.
  - When the timer reaches TIMEOUT, the partial word is discarded: count <= 0, shift_reg <= 0, state -> IDLE.
  - o_timeout pulses for one cycle. The timer is inactive in IDLE and STALL.
- Not defined: no timer logic; o_timeout is tied to 0 and the port remains present.

## Test plan
- Reset: hold i_rst_n low with i_en=1 -> o_ready=0, o_dout_valid=0, ov_dout=0. Release -> o_ready=1 combinationally.
- Single word: LENGTH=24, stream 0xA5C3F0 LSB first, i_ready=1 -> ov_dout=0xA5C3F0 with o_dout_valid high for exactly one cycle, starting at the 24th accept edge.
- Backpressure: i_ready=0, stream 0x000001 then 0x800000 -> ov_dout=0x000001 held, and o_ready=0 after the 48th bit (STALL). Raise i_ready for one cycle -> ov_dout=0x800000, o_dout_valid stays 1, o_ready=1.
- Gaps: random i_din_valid gaps and random i_en-low cycles while streaming 0x5A5A5A -> ov_dout=0x5A5A5A, with no bits dropped or duplicated.
- Reset mid-word: assert i_rst_n low after 10 bits, release, stream 0x123456 -> ov_dout=0x123456.
- Timeout (macro defined, TIMEOUT=32): 5 bits, then 32 idle enabled cycles -> o_timeout pulses once. Next 24 bits of 0xFEDCBA -> ov_dout=0xFEDCBA. Macro undefined -> o_timeout never rises, and the word is formed from the first 19 of those bits appended to the 5 held bits.

Source files
------------

// File: rtl/deserializer_fsm.sv
// -----------------------------------------------------------------------------
// deserializer_fsm
//
// Serial-to-parallel stage. Collects a single-bit stream, LSB first, into
// LENGTH-bit words and presents each word on a valid/ready output. The shift
// register and the output register are separate, so the next word can shift
// in while the previous one waits for the consumer.
//
// Optional feature macro: DESERIALIZER_TIMEOUT_EN
//   Defined   : a partial word idle for TIMEOUT enabled cycles is discarded,
//               and o_timeout pulses for one cycle.
//   Undefined : no timer logic; o_timeout is tied to 0.
//
// Parameters
//   LENGTH   word width in bits (>= 2)
//   TIMEOUT  idle-cycle limit for a partial word (>= 1, timeout build only)
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          clock enable; low freezes all state and drops o_ready
//   i_din         serial data bit
//   i_din_valid   i_din carries a bit this cycle
//   o_ready       stage accepts a bit this cycle (combinational)
//   ov_dout       assembled word, bit 0 = first bit received
//   o_dout_valid  ov_dout holds an unconsumed word
//   i_ready       consumer takes ov_dout when high with o_dout_valid
//   o_timeout     one-cycle pulse when a partial word is discarded
// -----------------------------------------------------------------------------
module deserializer_fsm #(
  parameter int LENGTH  = 24,
  parameter int TIMEOUT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_ready,
  output logic              o_timeout
);

  localparam int CW = $clog2(LENGTH + 1);

  if (LENGTH < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("deserializer_fsm: LENGTH must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [LENGTH-1:0] shift_reg, shift_nxt;
  logic [LENGTH-1:0] dout_nxt;
  logic              dout_valid_nxt;
  logic [LENGTH-1:0] shifted;
  logic              accept;
  logic              drain;
  logic              last_bit;
  logic              discard;

  assign o_ready  = i_rst_n & i_en & (state != STALL);
  assign accept   = i_en & i_din_valid & o_ready;
  assign drain    = i_en & o_dout_valid & i_ready;
  assign shifted  = {i_din, shift_reg[LENGTH-1:1]};
  assign last_bit = accept && (count == CW'(LENGTH - 1));

`ifdef DESERIALIZER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer, timer_nxt;

  // The timer only runs while a partial word sits in SHIFT without a new bit;
  // any accept, or leaving SHIFT, restarts it from zero.
  always_comb begin
    timer_nxt = '0;
    discard   = 1'b0;
    if (state == SHIFT && !accept) begin
      if (timer == TW'(TIMEOUT - 1)) begin
        discard = 1'b1;
      end else begin
        timer_nxt = timer + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timer     <= '0;
      o_timeout <= 1'b0;
    end else if (i_en) begin
      timer     <= timer_nxt;
      o_timeout <= discard;
    end
  end
`else
  assign discard   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Next-state, shift and output-register logic
  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    shift_nxt      = shift_reg;
    dout_nxt       = ov_dout;
    dout_valid_nxt = o_dout_valid;

    // A drain empties the output register unless a load below refills it.
    if (drain) begin
      dout_valid_nxt = 1'b0;
    end

    if (accept) begin
      shift_nxt = shifted;
      count_nxt = count + 1'b1;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (discard) begin
          count_nxt = '0;
          shift_nxt = '0;
          state_nxt = IDLE;
        end else if (last_bit) begin
          // A word completing in the same cycle as a drain replaces the old
          // word directly, so the output stays valid with no stall.
          if (!o_dout_valid || drain) begin
            dout_nxt       = shifted;
            dout_valid_nxt = 1'b1;
            count_nxt      = '0;
            state_nxt      = IDLE;
          end else begin
            state_nxt = STALL;
          end
        end
      end

      STALL: begin
        if (drain) begin
          dout_nxt       = shift_reg;
          dout_valid_nxt = 1'b1;
          count_nxt      = '0;
          state_nxt      = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      count        <= '0;
      shift_reg    <= '0;
      ov_dout      <= '0;
      o_dout_valid <= 1'b0;
    end else if (i_en) begin
      state        <= state_nxt;
      count        <= count_nxt;
      shift_reg    <= shift_nxt;
      ov_dout      <= dout_nxt;
      o_dout_valid <= dout_valid_nxt;
    end
  end

endmodule

// File: tb/tb_deserializer_fsm.sv
// -----------------------------------------------------------------------------
// tb_deserializer_fsm
//
// Directed testbench for deserializer_fsm (LENGTH=24, TIMEOUT=32). Inputs are
// driven on the falling edge; registered outputs are sampled 1ns after the
// rising edge. Timeout expectations follow DESERIALIZER_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_deserializer_fsm;

  localparam int LENGTH = 24;

`ifdef DESERIALIZER_TIMEOUT_EN
  localparam int EXP_PULSES = 1;
`else
  localparam int EXP_PULSES = 0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_en;
  logic              i_din;
  logic              i_din_valid;
  logic              i_ready;
  logic              o_ready;
  logic [LENGTH-1:0] ov_dout;
  logic              o_dout_valid;
  logic              o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  deserializer_fsm #(
    .LENGTH (24),
    .TIMEOUT(32)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_din       (i_din),
    .i_din_valid (i_din_valid),
    .o_ready     (o_ready),
    .ov_dout     (ov_dout),
    .o_dout_valid(o_dout_valid),
    .i_ready     (i_ready),
    .o_timeout   (o_timeout)
  );

  // Present one bit with enable high; confirm the stage is ready for it.
  task automatic send_bit(input logic b);
    @(negedge i_clk);
    i_en        = 1'b1;
    i_din       = b;
    i_din_valid = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: o_ready=%b expected 1 at %0t", o_ready, $time);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_bits(input logic [LENGTH-1:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_bit(w[i]);
    end
  endtask

  task automatic idle_cycle();
    @(negedge i_clk);
    i_en        = 1'b1;
    i_din_valid = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n     = 1'b0;
    i_en        = 1'b1;
    i_din       = 1'b0;
    i_din_valid = 1'b0;
    i_ready     = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n     = 1'b0;
    i_en        = 1'b1;
    i_din       = 1'b0;
    i_din_valid = 1'b0;
    i_ready     = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: o_ready=%b expected 0", o_ready);
    end
    n_checks++;
    if (o_dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: o_dout_valid=%b expected 0", o_dout_valid);
    end
    n_checks++;
    if (ov_dout !== 24'h000000) begin
      n_fail++; $display("FAIL reset_dout: ov_dout=%h expected 000000", ov_dout);
    end
    n_checks++;
    if (o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_timeout: o_timeout=%b expected 0", o_timeout);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: o_ready=%b expected 1", o_ready);
    end
  endtask

  task automatic test_single_word();
    logic [LENGTH-1:0] w;
    w = 24'hA5C3F0;
    do_reset();
    i_ready = 1'b1;
    send_bits(w, 0, 22);
    n_checks++;
    if (o_dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_early_valid: o_dout_valid=%b expected 0", o_dout_valid);
    end
    send_bit(w[23]);
    n_checks++;
    if (o_dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_valid: o_dout_valid=%b expected 1", o_dout_valid);
    end
    n_checks++;
    if (ov_dout !== 24'hA5C3F0) begin
      n_fail++; $display("FAIL single_dout: ov_dout=%h expected a5c3f0", ov_dout);
    end
    idle_cycle();
    n_checks++;
    if (o_dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_one_cycle: o_dout_valid=%b expected 0", o_dout_valid);
    end
    n_checks++;
    if (ov_dout !== 24'hA5C3F0) begin
      n_fail++; $display("FAIL single_dout_hold: ov_dout=%h expected a5c3f0", ov_dout);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_ready = 1'b0;
    send_bits(24'h000001, 0, 23);
    n_checks++;
    if (ov_dout !== 24'h000001 || o_dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_first: ov_dout=%h valid=%b expected 000001/1", ov_dout, o_dout_valid);
    end
    send_bits(24'h800000, 0, 23);
    n_checks++;
    if (o_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall_ready: o_ready=%b expected 0", o_ready);
    end
    n_checks++;
    if (ov_dout !== 24'h000001) begin
      n_fail++; $display("FAIL bp_held: ov_dout=%h expected 000001", ov_dout);
    end
    // A bit offered during the stall must be ignored.
    @(negedge i_clk);
    i_din       = 1'b1;
    i_din_valid = 1'b1;
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_ready !== 1'b0 || ov_dout !== 24'h000001) begin
      n_fail++; $display("FAIL bp_stall_hold: o_ready=%b ov_dout=%h expected 0/000001", o_ready, ov_dout);
    end
    @(negedge i_clk);
    i_din_valid = 1'b0;
    i_ready     = 1'b1;
    @(posedge i_clk);
    #1;
    n_checks++;
    if (ov_dout !== 24'h800000) begin
      n_fail++; $display("FAIL bp_release_dout: ov_dout=%h expected 800000", ov_dout);
    end
    n_checks++;
    if (o_dout_valid !== 1'b1 || o_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_flags: valid=%b ready=%b expected 1/1", o_dout_valid, o_ready);
    end
    send_bits(24'h00000F, 0, 23);
    n_checks++;
    if (ov_dout !== 24'h00000F || o_dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_next_word: ov_dout=%h valid=%b expected 00000f/1", ov_dout, o_dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [LENGTH-1:0] w;
    do_reset();
    i_ready = 1'b0;
    send_bits(24'h000001, 0, 23);
    w = 24'h3C3C3C;
    send_bits(w, 0, 22);
    // Drain lands on the same edge as completion of the second word.
    i_ready = 1'b1;
    send_bit(w[23]);
    n_checks++;
    if (ov_dout !== 24'h3C3C3C || o_dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_replace: ov_dout=%h valid=%b expected 3c3c3c/1", ov_dout, o_dout_valid);
    end
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_no_stall: o_ready=%b expected 1", o_ready);
    end
    send_bit(1'b1);
    n_checks++;
    if (o_dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drained: o_dout_valid=%b expected 0", o_dout_valid);
    end
    send_bits(24'h0F0F0F, 1, 23);
    n_checks++;
    if (ov_dout !== 24'h0F0F0F || o_dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_stream: ov_dout=%h valid=%b expected 0f0f0f/1", ov_dout, o_dout_valid);
    end
  endtask

  task automatic test_gaps();
    logic [LENGTH-1:0] w;
    w = 24'h5A5A5A;
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < LENGTH; i++) begin
      if (i % 3 == 1) begin
        @(negedge i_clk);
        i_en        = 1'b0;
        i_din       = ~w[i];
        i_din_valid = 1'b1;
        @(posedge i_clk);
        #1;
      end
      if (i % 4 == 2) begin
        idle_cycle();
        idle_cycle();
      end
      send_bit(w[i]);
    end
    n_checks++;
    if (ov_dout !== 24'h5A5A5A || o_dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL gaps_word: ov_dout=%h valid=%b expected 5a5a5a/1", ov_dout, o_dout_valid);
    end
    // Enable low must freeze the valid flag even with the consumer ready.
    @(negedge i_clk);
    i_en        = 1'b0;
    i_din_valid = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    n_checks++;
    if (o_dout_valid !== 1'b1 || o_ready !== 1'b0) begin
      n_fail++; $display("FAIL gaps_freeze: valid=%b ready=%b expected 1/0", o_dout_valid, o_ready);
    end
    idle_cycle();
    n_checks++;
    if (o_dout_valid !== 1'b0) begin
      n_fail++; $display("FAIL gaps_unfreeze: o_dout_valid=%b expected 0", o_dout_valid);
    end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    i_ready = 1'b1;
    send_bits(24'h0003FF, 0, 9);
    @(negedge i_clk);
    i_rst_n     = 1'b0;
    i_din_valid = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b0 || o_dout_valid !== 1'b0 || ov_dout !== 24'h000000) begin
      n_fail++; $display("FAIL midreset_state: ready=%b valid=%b dout=%h expected 0/0/000000", o_ready, o_dout_valid, ov_dout);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    send_bits(24'h123456, 0, 23);
    n_checks++;
    if (ov_dout !== 24'h123456 || o_dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_word: ov_dout=%h valid=%b expected 123456/1", ov_dout, o_dout_valid);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    do_reset();
    i_ready = 1'b1;
    send_bits(24'h000016, 0, 4);
    pulses = 0;
    for (int k = 0; k < 34; k++) begin
      idle_cycle();
      if (o_timeout === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== EXP_PULSES) begin
      n_fail++; $display("FAIL timeout_pulses: saw %0d pulses expected %0d", pulses, EXP_PULSES);
    end
`ifdef DESERIALIZER_TIMEOUT_EN
    send_bits(24'hFEDCBA, 0, 23);
    n_checks++;
    if (ov_dout !== 24'hFEDCBA || o_dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL timeout_word: ov_dout=%h valid=%b expected fedcba/1", ov_dout, o_dout_valid);
    end
`else
    send_bits(24'hFEDCBA, 0, 18);
    n_checks++;
    if (ov_dout !== 24'hDB9756 || o_dout_valid !== 1'b1) begin
      n_fail++; $display("FAIL notimeout_word: ov_dout=%h valid=%b expected db9756/1", ov_dout, o_dout_valid);
    end
    send_bits(24'hFEDCBA, 19, 23);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_gaps();
    test_reset_mid_word();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
